// File: rtl/cr_kme_fifo_arb.sv
// rtl/cr_kme_fifo_arb.sv - round-robin packet-locked arbiter feeding one KME staging FIFO
module cr_kme_fifo_arb #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 256,
    parameter int FREE_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    input  logic [N_REQ-1:0]           req_eop,
    input  logic [N_REQ-1:0]           req_enable,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [FREE_W-1:0]          fifo_free_slots,
    output logic [DATA_W-1:0]          fifo_in,
    output logic                       fifo_in_valid,
    output logic [$clog2(N_REQ)-1:0]   owner_id,
    output logic                       locked,
    output logic                       pkt_done
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win_idx;
    logic              win_found;
    logic [ID_W-1:0]   sel_id;
    logic [ID_W-1:0]   ptr_inc;
    logic              credit_ok;
    logic              accept;
    logic              acc_eop;

    // One slot is reserved for the beat already sitting in the output register.
    assign credit_ok = fifo_free_slots > (fifo_in_valid ? FREE_W'(1) : FREE_W'(0));

    always_comb begin : arb_search
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        // Scan downwards so the closest eligible index to rr_ptr is the last one kept.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (req_valid[idx] && req_enable[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    assign sel_id  = (state == LOCKED) ? owner_id : win_idx;
    assign acc_eop = req_eop[sel_id];
    assign accept  = !rst && credit_ok &&
                     ((state == LOCKED) ? req_valid[owner_id] : win_found);
    assign ptr_inc = (sel_id == ID_W'(N_REQ - 1)) ? '0 : sel_id + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !acc_eop) state_nxt = LOCKED;
            LOCKED:  if (accept && acc_eop)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[sel_id] = 1'b1;
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            owner_id      <= '0;
            pkt_done      <= 1'b0;
            fifo_in_valid <= 1'b0;
            fifo_in       <= '0;
        end else begin
            pkt_done      <= accept && acc_eop;
            fifo_in_valid <= accept;
            if (accept) begin
                fifo_in  <= req_data[int'(sel_id)*DATA_W +: DATA_W];
                owner_id <= sel_id;
                if (acc_eop) rr_ptr <= ptr_inc;
            end
        end
    end
endmodule

// File: tb/tb_cr_kme_fifo_arb.sv
// tb/tb_cr_kme_fifo_arb.sv - randomized scoreboard bench for cr_kme_fifo_arb
module tb_cr_kme_fifo_arb;
    localparam int N     = 4;
    localparam int W     = 256;
    localparam int FW    = 3;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_eop, req_enable, req_ready;
    logic [N*W-1:0]   req_data;
    logic [FW-1:0]    fifo_free_slots;
    logic [W-1:0]     fifo_in;
    logic             fifo_in_valid;
    logic [1:0]       owner_id;
    logic             locked, pkt_done;

    cr_kme_fifo_arb #(.N_REQ(N), .DATA_W(W), .FREE_W(FW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_eop(req_eop),
        .req_enable(req_enable), .req_ready(req_ready),
        .fifo_free_slots(fifo_free_slots),
        .fifo_in(fifo_in), .fifo_in_valid(fifo_in_valid),
        .owner_id(owner_id), .locked(locked), .pkt_done(pkt_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] sb_q[$];

    // requester side
    logic         vld[N];
    logic [W-1:0] cur_data[N];
    int           beat[N], len[N];
    int           p_valid, p_drain, max_len;
    logic [N-1:0] en;

    // reference model
    int   m_owner = -1;
    int   m_ptr = 0;
    int   m_oid = 0;
    logic m_inflight = 1'b0;
    logic m_done = 1'b0;
    int   occ = 0;
    logic wr_pending = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [W-1:0] d;
        for (int j = 0; j < W / 32; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic new_packet(input int i);
        beat[i]     = 0;
        len[i]      = $urandom_range(max_len, 1);
        cur_data[i] = rnd_data();
    endtask

    always @(negedge clk) begin
        if (fifo_in_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fifo_in: unexpected write of %0h", fifo_in);
            end else begin
                chk("fifo_in", fifo_in, sb_q.pop_front());
            end
        end
    end

    task automatic cycle(input bit do_rst);
        int  acc;
        bit  rd;
        logic [N-1:0] exp_ready;
        @(posedge clk);
        #1;
        rd  = (occ > 0) && ($urandom_range(99) < p_drain);
        occ = occ + int'(wr_pending) - int'(rd);
        checks++;
        if (occ > DEPTH) begin
            errors++;
            $display("FAIL fifo_overflow: occupancy %0d exceeds %0d", occ, DEPTH);
        end
        fifo_free_slots = FW'(DEPTH - occ);
        rst = do_rst;
        req_enable = en;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = vld[i];
            req_eop[i]         = (beat[i] == len[i] - 1);
            req_data[i*W +: W] = cur_data[i];
        end
        @(negedge clk);
        acc = -1;
        if (!do_rst && int'(fifo_free_slots) > (m_inflight ? 1 : 0)) begin
            if (m_owner >= 0) begin
                if (req_valid[m_owner]) acc = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (acc < 0 && req_valid[idx] && req_enable[idx]) acc = idx;
                end
            end
        end
        exp_ready = (acc >= 0) ? N'(1 << acc) : '0;
        chk("req_ready", req_ready, exp_ready);
        chk("fifo_in_valid", fifo_in_valid, m_inflight);
        chk("locked", locked, m_owner >= 0);
        chk("owner_id", owner_id, m_oid);
        chk("pkt_done", pkt_done, m_done);
        if (do_rst) begin
            m_owner = -1; m_ptr = 0; m_oid = 0; m_inflight = 0; m_done = 0;
        end else begin
            m_inflight = (acc >= 0);
            m_done     = 1'b0;
            if (acc >= 0) begin
                sb_q.push_back(cur_data[acc]);
                m_oid = acc;
                if (req_eop[acc]) begin
                    m_owner = -1;
                    m_ptr   = (acc + 1) % N;
                    m_done  = 1'b1;
                end else begin
                    m_owner = acc;
                end
            end
        end
        wr_pending = (fifo_in_valid === 1'b1);
        for (int i = 0; i < N; i++) begin
            if (do_rst) begin
                vld[i] = 1'b0;
                new_packet(i);
            end else if (vld[i] && req_ready[i] === 1'b1) begin
                beat[i]++;
                if (beat[i] >= len[i]) new_packet(i);
                else cur_data[i] = rnd_data();
                vld[i] = ($urandom_range(99) < p_valid);
            end else if (!vld[i]) begin
                vld[i] = ($urandom_range(99) < p_valid);
            end
        end
    endtask

    task automatic run(input int n, input int pv, input int pd, input int ml,
                       input logic [N-1:0] m, input bit mask_rand);
        p_valid = pv; p_drain = pd; max_len = ml; en = m;
        for (int c = 0; c < n; c++) begin
            if (mask_rand && (c % 25 == 0)) en = N'($urandom);
            cycle(1'b0);
        end
    endtask

    initial begin
        p_valid = 100; p_drain = 100; max_len = 1; en = '1;
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b1;
            new_packet(i);
        end
        rst = 1'b1;
        req_valid = '0; req_eop = '0; req_enable = '1; req_data = '0;
        fifo_free_slots = FW'(DEPTH);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_fifo_in", fifo_in, '0);
        chk("reset_fifo_in_valid", fifo_in_valid, 1'b0);
        chk("reset_locked", locked, 1'b0);
        chk("reset_pkt_done", pkt_done, 1'b0);
        chk("reset_owner_id", owner_id, '0);
        chk("reset_req_ready", req_ready, '0);

        run(40, 100, 100, 1, 4'b1111, 1'b0);   // single-beat round robin
        run(40, 100, 0, 4, 4'b1111, 1'b0);     // FIFO fills, no reads
        run(200, 100, 100, 4, 4'b1111, 1'b0);
        run(200, 70, 60, 4, 4'b0101, 1'b0);
        run(300, 40, 50, 6, 4'b1111, 1'b1);    // bubbles and mask changes
        for (int r = 0; r < 5; r++) begin
            int guard;
            guard = 0;
            p_valid = 80; p_drain = 80; max_len = 5; en = '1;
            while (!(m_owner >= 0 && m_inflight) && guard < 200) begin
                cycle(1'b0);
                guard++;
            end
            checks++;
            if (guard >= 200) begin
                errors++;
                $display("FAIL lock_wait: no locked packet within %0d cycles", guard);
            end
            cycle(1'b1);
            run(30, 80, 80, 5, 4'b1111, 1'b0);
        end
        run(600, 60, 55, 5, 4'b1111, 1'b1);
        run(30, 0, 100, 5, 4'b1111, 1'b0);
        chk("scoreboard_empty", W'(sb_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
